dmem_arbiter: RTL and testbench

//  Shares the single-port data-memory BRAM (regions 4'b0001/4'b0011) between the CPU memory stage
//  (port 0) and the DMA/loader engine (port 1). Sits after region decode and write-enable masking,
//  in front of the dmem BRAM. Stalls the CPU on conflict and routes 1-cycle-latency read data back.

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arbiter_stats.sv | 47 ++++
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the dmem arbiter: region nibbles, port ids, statistics selectors.
package dmem_arbiter_pkg;

  localparam logic [3:0] REGION_DMEM      = 4'b0001;
  localparam logic [3:0] REGION_DMEM_IMEM = 4'b0011;
  localparam logic [3:0] REGION_BIOS      = 4'b0100;
  localparam logic [3:0] REGION_IO        = 4'b1000;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_e;

  typedef enum logic [1:0] {
    STAT_CPU_GNT  = 2'd0,
    STAT_DMA_GNT  = 2'd1,
    STAT_CONFLICT = 2'd2,
    STAT_FORCED   = 2'd3
  } stat_sel_e;

endpackage

// File: rtl/dmem_arbiter_stats.sv
// Wrapping 32-bit arbitration event counters with a registered read-out mux.
module dmem_arb_stats
  import dmem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_gnt,
  input  logic        dma_gnt,
  input  logic        conflict,
  input  logic        forced,
  input  logic [1:0]  stat_sel,
  output logic [31:0] stat_data
);

  logic [31:0] cpu_cnt_q, dma_cnt_q, conf_cnt_q, forced_cnt_q;
  logic [31:0] stat_d, stat_q;

  always_comb begin
    stat_d = '0;
    case (stat_sel_e'(stat_sel))
      STAT_CPU_GNT:  stat_d = cpu_cnt_q;
      STAT_DMA_GNT:  stat_d = dma_cnt_q;
      STAT_CONFLICT: stat_d = conf_cnt_q;
      STAT_FORCED:   stat_d = forced_cnt_q;
      default:       stat_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_cnt_q    <= '0;
      dma_cnt_q    <= '0;
      conf_cnt_q   <= '0;
      forced_cnt_q <= '0;
      stat_q       <= '0;
    end else begin
      cpu_cnt_q    <= cpu_cnt_q + 32'(cpu_gnt);
      dma_cnt_q    <= dma_cnt_q + 32'(dma_gnt);
      conf_cnt_q   <= conf_cnt_q + 32'(conflict);
      forced_cnt_q <= forced_cnt_q + 32'(forced);
      stat_q       <= stat_d;
    end
  end

  assign stat_data = stat_q;

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter in front of the single-port dmem BRAM, with DMA anti-starvation.
// Optional statistics counters built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dma_req,
  input  logic [3:0]        dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic [1:0]        stat_sel,
  output logic [31:0]       stat_data
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q, starve_d;
  logic          rd_pend_q, rd_pend_d;
  port_e         rd_owner_q, rd_owner_d;
  logic          both, forced, dma_win, cpu_gnt;

  always_comb begin
    both      = cpu_req & dma_req;
    forced    = both & (starve_q == SMAX);
    dma_win   = dma_req & (~cpu_req | forced);
    cpu_gnt   = ~rst & cpu_req & ~dma_win;
    dma_gnt   = ~rst & dma_win;
    cpu_stall = ~rst & cpu_req & ~cpu_gnt;

    mem_en    = cpu_gnt | dma_gnt;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr[ADDR_W+1:2];
      mem_wdata = dma_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr[ADDR_W+1:2];
      mem_wdata = cpu_wdata;
    end

    // Streak of lost conflict cycles; any DMA grant or DMA idle cycle breaks it.
    starve_d = starve_q;
    if (!dma_req || dma_gnt)
      starve_d = '0;
    else if (both && starve_q != SMAX)
      starve_d = starve_q + CW'(1);

    rd_pend_d  = mem_en & (mem_we == 4'b0000);
    rd_owner_d = dma_gnt ? PORT_DMA : PORT_CPU;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q   <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= PORT_CPU;
    end else begin
      starve_q   <= starve_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Gated by rst so a read in flight when reset rises is never reported.
  assign cpu_rvalid = ~rst & rd_pend_q & (rd_owner_q == PORT_CPU);
  assign dma_rvalid = ~rst & rd_pend_q & (rd_owner_q == PORT_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                              dma_addr[31:ADDR_W+2], dma_addr[1:0]};

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats u_stats (
    .clk      (clk),
    .rst      (rst),
    .cpu_gnt  (cpu_gnt),
    .dma_gnt  (dma_gnt),
    .conflict (~rst & both),
    .forced   (~rst & forced),
    .stat_sel (stat_sel),
    .stat_data(stat_data)
  );
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_data       = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios followed by randomized traffic.
module tb_dmem_arbiter;
  localparam int ADDR_W = 12;
  localparam int SM     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_req = 0, dma_req = 0;
  logic [3:0] cpu_we = '0, dma_we = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
  logic [1:0] stat_sel = '0;
  logic cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_en;
  logic [31:0] cpu_rdata, dma_rdata, mem_wdata, stat_data;
  logic [31:0] mem_rdata = '0;
  logic [3:0] mem_we;
  logic [ADDR_W-1:0] mem_addr;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stat_sel(stat_sel), .stat_data(stat_data)
  );

  // Environment BRAM: one-cycle read latency, byte-lane writes.
  logic [31:0] bram [4096];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000) mem_rdata <= bram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic stall, dg, en;
    logic [3:0] we;
    logic [31:0] ad, wd;
    logic cv, dv;
    logic [31:0] cr, dr;
    logic chk_stat;
    logic [31:0] sd;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  logic [31:0] ref_mem [4096];
  int          streak = 0;
  bit          pend = 0, pend_dma = 0;
  logic [31:0] pend_data = '0;
  int unsigned cnt [4];
  logic [31:0] stat_prev = '0;
  bit          stat_known = 0;

  int n_checks = 0, n_fail = 0;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, expv, $time);
    end
  endtask

  // One cycle of stimulus; predicts the DUT response from the arbitration rules.
  task automatic step(input bit r, input bit creq, input logic [3:0] cwe, input logic [31:0] ca,
                      input logic [31:0] cwd, input bit dreq, input logic [3:0] dwe,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [1:0] sel,
                      output bit dg_o);
    exp_t e;
    bit both, dwin;
    int idx;
    @(posedge clk);
    #1;
    rst = r; cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = da; dma_wdata = dwd; stat_sel = sel;
    e = '{default: '0};
    if (r) begin
      streak = 0; pend = 0; stat_prev = '0; stat_known = 1;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
    end else begin
      e.cv = pend && !pend_dma;
      e.dv = pend && pend_dma;
      e.cr = e.cv ? pend_data : '0;
      e.dr = e.dv ? pend_data : '0;
      both = creq && dreq;
      dwin = dreq && (!creq || streak >= SM);
      e.dg = dwin;
      e.stall = creq && dwin;
      e.en = creq || dreq;
      pend = 0;
      if (e.en) begin
        e.we = dwin ? dwe : cwe;
        e.ad = 32'((dwin ? da : ca) >> 2) & 32'hFFF;
        e.wd = dwin ? dwd : cwd;
        idx  = int'(e.ad);
        if (e.we == 4'b0000) begin
          pend = 1; pend_dma = dwin; pend_data = ref_mem[idx];
        end else begin
          for (int b = 0; b < 4; b++)
            if (e.we[b]) ref_mem[idx][8*b +: 8] = e.wd[8*b +: 8];
        end
      end
      if (!dreq || dwin) streak = 0;
      else if (both) streak = (streak + 1 > SM) ? SM : streak + 1;
      e.chk_stat = stat_known;
      e.sd = stat_prev;
      stat_prev = 32'(cnt[sel]);
      cnt[0] += (creq && !dwin) ? 1 : 0;
      cnt[1] += dwin ? 1 : 0;
      cnt[2] += both ? 1 : 0;
      cnt[3] += (both && dwin) ? 1 : 0;
    end
`ifndef DMEM_ARB_STATS_EN
    e.chk_stat = 1; e.sd = '0;
`endif
    dg_o = e.dg;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expected record per cycle and compares the DUT's outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cpu_stall", 32'(cpu_stall), 32'(e.stall));
        chk("dma_gnt", 32'(dma_gnt), 32'(e.dg));
        chk("mem_en", 32'(mem_en), 32'(e.en));
        chk("mem_we", 32'(mem_we), 32'(e.we));
        if (e.en) chk("mem_addr", 32'(mem_addr), e.ad);
        if (e.en && e.we != 4'b0000) chk("mem_wdata", mem_wdata, e.wd);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e.cv));
        chk("dma_rvalid", 32'(dma_rvalid), 32'(e.dv));
        chk("cpu_rdata", cpu_rdata, e.cr);
        chk("dma_rdata", dma_rdata, e.dr);
        if (e.chk_stat) chk("stat_data", stat_data, e.sd);
      end
    end
  end

  initial begin
    bit dg, dhold;
    bit creq, dreq, r;
    logic [3:0] cwe, dwe;
    logic [31:0] ca, cwd, da, dwd;
    for (int i = 0; i < 4096; i++) begin
      bram[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end

    // Reset held two cycles with both ports requesting
    repeat (2) step(1, 1, 4'h0, 32'h1000_0000, 0, 1, 4'h0, 32'h1000_0004, 0, 2'd0, dg);
    // CPU-only read of byte address 0x1000_0010 -> word 4
    step(0, 1, 4'h0, 32'h1000_0010, 0, 0, 4'h0, 0, 0, 2'd0, dg);
    step(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 2'd2, dg);
    // Ten conflict cycles of reads
    for (int i = 0; i < 10; i++)
      step(0, 1, 4'h0, 32'h1000_0000 + 32'(4 * i), 0, 1, 4'h0, 32'h1000_000C, 0, 2'(i), dg);
    step(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 2'd3, dg);
    // DMA write to word 8 contending with CPU reads of word 8 until the forced DMA win
    dg = 0;
    for (int i = 0; i < 8 && !dg; i++)
      step(0, 1, 4'h0, 32'h1000_0020, 0, 1, 4'hF, 32'h1000_0020, 32'hDEAD_BEEF, 2'd1, dg);
    step(0, 1, 4'h0, 32'h1000_0020, 0, 0, 4'h0, 0, 0, 2'd0, dg);
    step(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 2'd0, dg);
    // Reset with a CPU read in flight
    step(0, 1, 4'h0, 32'h1000_0040, 0, 0, 4'h0, 0, 0, 2'd0, dg);
    step(1, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 2'd0, dg);
    step(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 2'd0, dg);

    // Randomized traffic; DMA holds its request stable until granted
    dhold = 0; dreq = 0; dwe = '0; da = '0; dwd = '0;
    for (int c = 0; c < 400; c++) begin
      r    = ($urandom_range(0, 59) == 0);
      creq = ($urandom_range(0, 9) < 6);
      cwe  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      ca   = {4'h1, 14'($urandom), 12'($urandom_range(0, 15)), 2'($urandom)};
      cwd  = $urandom;
      if (!dhold) begin
        dreq = ($urandom_range(0, 9) < 6);
        dwe  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        da   = {4'h3, 14'($urandom), 12'($urandom_range(0, 15)), 2'($urandom)};
        dwd  = $urandom;
      end
      step(r, creq, cwe, ca, cwd, dreq, dwe, da, dwd, 2'($urandom), dg);
      dhold = dreq && !dg;
    end
    step(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 2'd0, dg);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
